// File: rtl/label_feature_accumulator_if.sv
// label_feature_accumulator_if: pixel input, readout stream and status bundle for the label feature accumulator.
interface label_feature_accumulator_if #(
   parameter int LABEL_WIDTH = 8,
   parameter int COORD_WIDTH = 12,
   parameter int AREA_WIDTH  = 20
);
   logic                   en;
   logic [LABEL_WIDTH-1:0] label;
   logic [31:0]            x;
   logic [31:0]            y;
   logic                   frame_end;
   logic                   busy;
   logic                   out_valid;
   logic                   out_ready;
   logic [LABEL_WIDTH-1:0] out_label;
   logic [AREA_WIDTH-1:0]  out_area;
   logic [COORD_WIDTH-1:0] out_x_min;
   logic [COORD_WIDTH-1:0] out_x_max;
   logic [COORD_WIDTH-1:0] out_y_min;
   logic [COORD_WIDTH-1:0] out_y_max;
   logic                   done;
   modport master (
      output en, label, x, y, frame_end, out_ready,
      input  busy, out_valid, out_label, out_area, out_x_min, out_x_max, out_y_min, out_y_max, done
   );
   modport slave (
      input  en, label, x, y, frame_end, out_ready,
      output busy, out_valid, out_label, out_area, out_x_min, out_x_max, out_y_min, out_y_max, done
   );
endinterface

// File: rtl/label_feature_accumulator.sv
// label_feature_accumulator: per-label area and bounding box over a labeled pixel stream,
// streamed out in label order at frame end and then cleared.
module label_feature_accumulator #(
   parameter int LABEL_WIDTH = 8,
   parameter int COORD_WIDTH = 12,
   parameter int AREA_WIDTH  = 20
) (
   input logic clk,
   input logic reset_n,
   label_feature_accumulator_if.slave bus
);
   localparam int N = 2 ** LABEL_WIDTH;
   localparam logic [1:0] ACCUM   = 2'd0;
   localparam logic [1:0] FLUSH   = 2'd1;
   localparam logic [1:0] READOUT = 2'd2;
   localparam logic [1:0] CLEAR   = 2'd3;

   typedef struct packed {
      logic [AREA_WIDTH-1:0]  area;
      logic [COORD_WIDTH-1:0] x_min;
      logic [COORD_WIDTH-1:0] x_max;
      logic [COORD_WIDTH-1:0] y_min;
      logic [COORD_WIDTH-1:0] y_max;
   } ent_t;

   ent_t mem [N];
   ent_t rd_q, bd_q, old_e, new_e;
   logic [N-1:0] vb_q;
   logic [1:0] st_q, st_d;
   logic v1_q, byp_q, fl_q, scan_q, ov_q, done_q;
   logic [LABEL_WIDTH-1:0] l1_q, addr_q, ol_q, rd_addr;
   logic [COORD_WIDTH-1:0] x1_q, y1_q;
   logic acc_rd, hs, scan_step, scan_rd, last_step, fin, hit;
   logic unused_hi;

   assign unused_hi = ^{bus.x[31:COORD_WIDTH], bus.y[31:COORD_WIDTH]};

   always_comb begin
      acc_rd    = st_q == ACCUM && bus.en && bus.label != '0;
      hs        = ov_q && bus.out_ready;
      scan_step = st_q == READOUT && scan_q && (!ov_q || bus.out_ready);
      scan_rd   = scan_step && vb_q[addr_q];
      last_step = scan_step && addr_q == '1;
      fin       = (last_step && !vb_q[addr_q]) || (st_q == READOUT && !scan_q && hs);
      rd_addr   = scan_rd ? addr_q : bus.label;
      // The previous cycle's write to this label raced the RAM read, so take its data instead
      old_e     = byp_q ? bd_q : rd_q;
      hit       = vb_q[l1_q];
      new_e.area  = !hit ? AREA_WIDTH'(1) : (&old_e.area ? old_e.area : old_e.area + AREA_WIDTH'(1));
      new_e.x_min = (!hit || x1_q < old_e.x_min) ? x1_q : old_e.x_min;
      new_e.x_max = (!hit || x1_q > old_e.x_max) ? x1_q : old_e.x_max;
      new_e.y_min = (!hit || y1_q < old_e.y_min) ? y1_q : old_e.y_min;
      new_e.y_max = (!hit || y1_q > old_e.y_max) ? y1_q : old_e.y_max;
      st_d = st_q == ACCUM   ? (bus.frame_end ? FLUSH : ACCUM) :
             st_q == FLUSH   ? (fl_q ? READOUT : FLUSH) :
             st_q == READOUT ? (done_q ? CLEAR : READOUT) : ACCUM;
   end

   always_ff @(posedge clk) begin
      if (v1_q) mem[l1_q] <= new_e;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_q   <= ACCUM;
         vb_q   <= '0;
         rd_q   <= '0;
         bd_q   <= '0;
         v1_q   <= 1'b0;
         byp_q  <= 1'b0;
         l1_q   <= '0;
         x1_q   <= '0;
         y1_q   <= '0;
         fl_q   <= 1'b0;
         scan_q <= 1'b0;
         addr_q <= '0;
         ov_q   <= 1'b0;
         ol_q   <= '0;
         done_q <= 1'b0;
      end else begin
         st_q  <= st_d;
         v1_q  <= acc_rd;
         if (acc_rd) begin
            l1_q <= bus.label;
            x1_q <= bus.x[COORD_WIDTH-1:0];
            y1_q <= bus.y[COORD_WIDTH-1:0];
         end
         byp_q <= v1_q && acc_rd && l1_q == bus.label;
         bd_q  <= new_e;
         if (acc_rd || scan_rd) rd_q <= mem[rd_addr];
         if (st_q == CLEAR) vb_q <= '0;
         else if (v1_q) vb_q[l1_q] <= 1'b1;
         fl_q <= st_q == FLUSH && !fl_q;
         if (st_q == FLUSH && fl_q) begin
            scan_q <= 1'b1;
            addr_q <= LABEL_WIDTH'(1);
         end else if (scan_step) begin
            scan_q <= !last_step;
            addr_q <= addr_q + LABEL_WIDTH'(1);
         end
         // rd_q doubles as the record register: it only reloads once the held record is taken
         if (scan_step) begin
            ov_q <= scan_rd;
            if (scan_rd) ol_q <= addr_q;
         end else if (hs) ov_q <= 1'b0;
         done_q <= fin;
      end
   end

   assign bus.busy      = st_q != ACCUM;
   assign bus.out_valid = ov_q;
   assign bus.out_label = ol_q;
   assign bus.out_area  = rd_q.area;
   assign bus.out_x_min = rd_q.x_min;
   assign bus.out_x_max = rd_q.x_max;
   assign bus.out_y_min = rd_q.y_min;
   assign bus.out_y_max = rd_q.y_max;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_label_feature_accumulator.sv
// tb_label_feature_accumulator: directed frames against a 20-bit-area and a 4-bit-area instance
// sharing one stimulus stream.
module tb_label_feature_accumulator;
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   label_feature_accumulator_if #(8, 12, 20) ifc ();
   label_feature_accumulator_if #(8, 12, 4)  ifc4 ();
   assign ifc4.en        = ifc.en;
   assign ifc4.label     = ifc.label;
   assign ifc4.x         = ifc.x;
   assign ifc4.y         = ifc.y;
   assign ifc4.frame_end = ifc.frame_end;
   assign ifc4.out_ready = ifc.out_ready;

   label_feature_accumulator #(.LABEL_WIDTH(8), .COORD_WIDTH(12), .AREA_WIDTH(20)) dut (
      .clk(clk), .reset_n(reset_n), .bus(ifc.slave));
   label_feature_accumulator #(.LABEL_WIDTH(8), .COORD_WIDTH(12), .AREA_WIDTH(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .bus(ifc4.slave));

   typedef struct {int l, a, a4, x0, x1, y0, y1;} rec_t;
   rec_t recs[$];
   int total = 0;
   int bad = 0;
   int cyc, first_ov;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic pix(input int l, input int px, input int py, input bit fe);
      @(negedge clk);
      ifc.en = 1'b1;
      ifc.label = 8'(l);
      ifc.x = px;
      ifc.y = py;
      ifc.frame_end = fe;
   endtask

   task automatic readout(input int hold);
      int w;
      bit fin;
      rec_t cur;
      w = 0;
      fin = 0;
      cyc = 0;
      first_ov = 0;
      cur = '{0, 0, 0, 0, 0, 0, 0};
      recs.delete();
      while (!fin && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         ifc.en = 1'b0;
         ifc.frame_end = 1'b0;
         if (ifc.done) begin
            chk("done_with_valid", int'(ifc.out_valid), 0);
            ifc.out_ready = 1'b0;
            fin = 1;
         end else if (ifc.out_valid) begin
            if (first_ov == 0) first_ov = cyc;
            if (w == 0) begin
               cur.l = ifc.out_label; cur.a = ifc.out_area; cur.a4 = ifc4.out_area;
               cur.x0 = ifc.out_x_min; cur.x1 = ifc.out_x_max;
               cur.y0 = ifc.out_y_min; cur.y1 = ifc.out_y_max;
            end else begin
               chk("stall_label", int'(ifc.out_label), cur.l);
               chk("stall_area", int'(ifc.out_area), cur.a);
               chk("stall_xmax", int'(ifc.out_x_max), cur.x1);
            end
            if (w < hold) begin
               ifc.out_ready = 1'b0;
               w++;
            end else begin
               ifc.out_ready = 1'b1;
               recs.push_back(cur);
               w = 0;
            end
         end else ifc.out_ready = (hold == 0);
      end
      if (!fin) chk("done_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (ifc.busy && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("busy_fall", int'(ifc.busy), 0);
   endtask

   task automatic chk_rec(input int i, input int l, input int a, input int x0, input int x1,
                          input int y0, input int y1);
      if (i >= recs.size()) chk("rec_missing", recs.size(), i + 1);
      else begin
         chk("rec_label", recs[i].l, l);
         chk("rec_area", recs[i].a, a);
         chk("rec_xmin", recs[i].x0, x0);
         chk("rec_xmax", recs[i].x1, x1);
         chk("rec_ymin", recs[i].y0, y0);
         chk("rec_ymax", recs[i].y1, y1);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      ifc.en = 1'b0; ifc.label = '0; ifc.x = '0; ifc.y = '0;
      ifc.frame_end = 1'b0; ifc.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(ifc.busy), 0);
      chk("rst_valid", int'(ifc.out_valid), 0);
      chk("rst_done", int'(ifc.done), 0);
      chk("rst_area", int'(ifc.out_area), 0);
      chk("rst_label", int'(ifc.out_label), 0);
      reset_n = 1'b1;

      pix(3, 5, 2, 0); pix(3, 9, 2, 0); pix(3, 7, 4, 0); pix(0, 0, 0, 1);
      readout(0);
      chk("basic_count", recs.size(), 1);
      chk_rec(0, 3, 3, 5, 9, 2, 4);
      wait_idle();

      for (int i = 0; i < 4; i++) pix(7, 10 + i, 0, 0);
      pix(0, 0, 0, 1);
      @(negedge clk);
      ifc.en = 1'b0; ifc.frame_end = 1'b0;
      chk("busy_rise", int'(ifc.busy), 1);
      readout(0);
      chk("bypass_count", recs.size(), 1);
      chk_rec(0, 7, 4, 10, 13, 0, 0);
      wait_idle();

      pix(0, 1, 1, 0); pix(0, 2, 2, 0); pix(0, 3, 3, 1);
      readout(0);
      chk("empty_count", recs.size(), 0);
      chk("empty_first_valid", first_ov, 0);
      chk("empty_done_cycle", cyc, 258);
      wait_idle();

      pix(200, 100, 50, 0); pix(1, 3, 3, 0); pix(2, 4, 5, 0); pix(200, 90, 60, 0);
      pix(0, 0, 0, 1);
      readout(5);
      chk("first_valid_cycle", first_ov, 4);
      chk("bp_count", recs.size(), 3);
      chk_rec(0, 1, 1, 3, 3, 3, 3);
      chk_rec(1, 2, 1, 4, 4, 5, 5);
      chk_rec(2, 200, 2, 90, 100, 50, 60);
      wait_idle();

      pix(2, 1, 1, 0); pix(2, 6, 7, 1);
      readout(0);
      chk("simul_count", recs.size(), 1);
      chk_rec(0, 2, 2, 1, 6, 1, 7);
      wait_idle();
      pix(2, 3, 3, 1);
      readout(0);
      chk("clear_count", recs.size(), 1);
      chk_rec(0, 2, 1, 3, 3, 3, 3);
      wait_idle();

      pix(5, 1, 1, 0); pix(9, 8, 8, 0); pix(0, 0, 0, 1);
      cyc = 0;
      while (!ifc.out_valid && cyc < 20) begin
         @(negedge clk);
         ifc.en = 1'b0; ifc.frame_end = 1'b0;
         cyc++;
      end
      chk("pre_reset_valid", int'(ifc.out_valid), 1);
      reset_n = 1'b0;
      #1;
      chk("async_rst_valid", int'(ifc.out_valid), 0);
      chk("async_rst_busy", int'(ifc.busy), 0);
      @(negedge clk);
      reset_n = 1'b1;
      pix(9, 2, 2, 1);
      readout(0);
      chk("post_reset_count", recs.size(), 1);
      chk_rec(0, 9, 1, 2, 2, 2, 2);
      wait_idle();

      for (int i = 0; i < 20; i++) pix(4, 32'h10000 + i, 3, 0);
      pix(0, 0, 0, 1);
      readout(0);
      chk("sat_count", recs.size(), 1);
      chk_rec(0, 4, 20, 0, 19, 3, 3);
      if (recs.size() > 0) chk("sat_area4", recs[0].a4, 15);
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
